// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-transaction Wishbone pipelined master driven by a command strobe.
// Define WBM_TIMEOUT_EN to build the request-to-ack timeout counter and o_rsp_timeout.
module wb_cmd_master #(
  parameter int AW = 30,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cmd_stb,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  input  logic [DW/8-1:0] i_cmd_sel,
  input  logic            i_abort,
  output logic            o_cmd_busy,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_stall,
  input  logic            i_wb_ack,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic            o_rsp_stb,
  output logic            o_rsp_err,
  output logic            o_rsp_timeout,
  output logic [DW-1:0]   o_rsp_data
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic tmo, bus_done, ack_ok, done;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..65535");
  end
  // ack/err only count once the request has been accepted (stall low in REQ)
  assign bus_done = (state == WAIT || (state == REQ && !i_wb_stall)) && (i_wb_ack || i_wb_err);
  assign ack_ok = bus_done && !i_wb_err && !i_abort;
  assign done = i_abort || bus_done || tmo;
`ifdef WBM_TIMEOUT_EN
  logic [15:0] cnt;
  assign tmo = cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (cnt != '1) cnt <= cnt + 16'd1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      o_cmd_busy <= 1'b0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_wb_sel <= '0;
      o_rsp_stb <= 1'b0;
      o_rsp_err <= 1'b0;
      o_rsp_timeout <= 1'b0;
      o_rsp_data <= '0;
    end else begin
      o_rsp_stb <= 1'b0;
      o_rsp_err <= 1'b0;
      o_rsp_timeout <= 1'b0;
      if (state == IDLE) begin
        if (i_cmd_stb) begin
          o_wb_we <= i_cmd_we;
          o_wb_addr <= i_cmd_addr;
          o_wb_data <= i_cmd_data;
          o_wb_sel <= i_cmd_sel;
          o_wb_cyc <= 1'b1;
          o_wb_stb <= 1'b1;
          o_cmd_busy <= 1'b1;
          state <= REQ;
        end
      end else if (done) begin
        o_wb_cyc <= 1'b0;
        o_wb_stb <= 1'b0;
        o_cmd_busy <= 1'b0;
        o_rsp_stb <= 1'b1;
        o_rsp_err <= !ack_ok;
        o_rsp_timeout <= !i_abort && !bus_done && tmo;
        if (ack_ok && !o_wb_we) o_rsp_data <= i_wb_data;
        state <= IDLE;
      end else if (state == REQ && !i_wb_stall) begin
        o_wb_stb <= 1'b0;
        state <= WAIT;
      end
    end
  end
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized transactions checked against a cycle-index model of the master.
module tb_wb_cmd_master;
  localparam int AW = 30, DW = 32, TO = 16, NONE = 1000;
  logic clk = 0, rst = 1;
  logic cmd_stb = 0, cmd_we = 0, abort = 0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [3:0] cmd_sel = '0;
  logic busy, cyc, stb, we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata, bus_rdata = '0;
  logic [3:0] sel;
  logic stall = 0, ack = 0, err = 0;
  logic rsp_stb, rsp_err, rsp_to;
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] exp_rdata = '0;
  always #5 clk = ~clk;
  wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset(rst), .i_cmd_stb(cmd_stb), .i_cmd_we(cmd_we),
    .i_cmd_addr(cmd_addr), .i_cmd_data(cmd_data), .i_cmd_sel(cmd_sel), .i_abort(abort),
    .o_cmd_busy(busy), .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_addr(addr),
    .o_wb_data(wdata), .o_wb_sel(sel), .i_wb_stall(stall), .i_wb_ack(ack), .i_wb_err(err),
    .i_wb_data(bus_rdata), .o_rsp_stb(rsp_stb), .o_rsp_err(rsp_err),
    .o_rsp_timeout(rsp_to), .o_rsp_data(rdata)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_cyc", cyc, 0);
      chk("idle_rsp", rsp_stb, 0);
    end
  endtask
  // kind: 0 = slave acks, 1 = slave errs, 2 = slave never answers.
  // s stall cycles, answer d cycles after acceptance, abort in cycle a (0 = never).
  task automatic txn(input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] dt,
                     input logic [3:0] sl, input int s, input int kind, input int d,
                     input int a, input logic [DW-1:0] rd, input bit poke);
    int r, e, tm;
    logic x_err, x_to;
    r = (kind == 2) ? NONE : s + 1 + d;
    tm = NONE;
`ifdef WBM_TIMEOUT_EN
    tm = TO;
`endif
    e = r;
    if (a > 0 && a < e) e = a;
    if (tm < e) e = tm;
    if (e >= NONE) begin
      chk("txn_never_ends", 1, 0);
      return;
    end
    x_err = (a == e) || (r != e) || (kind == 1);
    x_to = (a != e) && (r != e);
    chk("start_cyc", cyc, 0);
    chk("start_busy", busy, 0);
    cmd_stb = 1; cmd_we = w; cmd_addr = ad; cmd_data = dt; cmd_sel = sl;
    for (int c = 1; c <= e + 1; c++) begin
      tick();
      cmd_stb = poke && e >= 2 && c == 2;
      cmd_addr = ~ad;
      stall = c <= s;
      ack = kind == 0 && c == r;
      err = kind == 1 && c == r;
      abort = c == a;
      bus_rdata = (c == r) ? rd : DW'($urandom);
      if (c <= e) begin
        chk("cyc", cyc, 1);
        chk("stb", stb, c <= s + 1);
        chk("busy", busy, 1);
        chk("rsp_early", rsp_stb, 0);
        if (c <= s + 1) begin
          chk("addr", addr, ad);
          chk("we", we, w);
          chk("wdata", wdata, dt);
          chk("sel", sel, sl);
        end
      end else begin
        if (!x_err && !w) exp_rdata = rd;
        chk("rsp_stb", rsp_stb, 1);
        chk("rsp_err", rsp_err, x_err);
        chk("rsp_to", rsp_to, x_to);
        chk("rsp_data", rdata, exp_rdata);
        chk("end_cyc", cyc, 0);
        chk("end_stb", stb, 0);
        chk("end_busy", busy, 0);
      end
    end
    cmd_stb = 0; stall = 0; ack = 0; err = 0; abort = 0;
  endtask
  initial begin
    int kind, a;
    tick();
    tick();
    chk("rst_cyc", cyc, 0);
    chk("rst_stb", stb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_stb, rsp_err, rsp_to}, 0);
    chk("rst_regs", {we, addr, wdata, sel}, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    tick();
    txn(1, 30'h2081, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0, 0, 0);
    idle(1);
    txn(0, 30'h2080, 0, 4'hF, 3, 0, 1, 0, 32'h20170622, 0);
    idle(1);
    txn(0, 30'h0, 0, 4'hF, 0, 1, 1, 0, 32'h12345678, 0);
    idle(1);
`ifdef WBM_TIMEOUT_EN
    txn(0, 30'h10, 0, 4'h3, 2, 2, 0, 0, 0, 0);
`else
    txn(0, 30'h10, 0, 4'h3, 2, 2, 0, 30, 0, 0);
`endif
    idle(1);
    txn(0, 30'h11, 0, 4'hF, 1, 0, 2, 3, 32'hCAFE0001, 0);
    txn(1, 30'h12, 32'h55AA55AA, 4'h5, 0, 0, 3, 0, 0, 1);
    txn(0, 30'h13, 0, 4'hF, 0, 0, 0, 0, 32'h0BADF00D, 0);
    idle(3);
    ack = 1; err = 1; abort = 1;
    idle(2);
    ack = 0; err = 0; abort = 0;
    cmd_stb = 1; cmd_we = 0; cmd_addr = 30'h2082; cmd_sel = 4'hF;
    tick();
    cmd_stb = 0;
    tick();
    chk("pre_rst_wait", {cyc, stb}, 2'b10);
    #2;
    rst = 1;
    #1;
    chk("async_rst", {cyc, stb, busy}, 0);
    tick();
    chk("rst_no_rsp", rsp_stb, 0);
    rst = 0;
    exp_rdata = '0;
    tick();
    txn(0, 30'h2082, 0, 4'hF, 1, 0, 1, 0, 32'h600DCAFE, 0);
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(9) < 6 ? 0 : ($urandom_range(1) == 0 ? 1 : 2);
      a = $urandom_range(3) == 0 ? $urandom_range(1, 8) : 0;
`ifndef WBM_TIMEOUT_EN
      if (kind == 2 && a == 0) a = $urandom_range(1, 20);
`endif
      txn($urandom_range(1), AW'($urandom), DW'($urandom), 4'($urandom_range(15)),
          $urandom_range(4), kind, $urandom_range(4), a, DW'($urandom), $urandom_range(1) == 1);
      idle($urandom_range(2));
    end
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-transaction Wishbone pipelined-mode bus master.
- Turns a simple command strobe (read or write, address, data, select) into one bus cycle toward the board's slave decode: FM generator, simple device, and LO/EFB pages.
- Returns the read data or error as a one-cycle response strobe.
- Lets on-chip sequencers (e.g. sweep or calibration logic) share the slave bus with the UART bridge through an arbiter upstream.

Parameters:
- AW, 30, Wishbone word-address width.
- DW, 32, data width.
- TIMEOUT_CYCLES, 255, cycles allowed from bus request to ack/err before timeout abort (range 2..65535).

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_cmd_stb  in  1  command request; accepted when o_cmd_busy=0.
- i_cmd_we  in  1  1 = write, 0 = read.
- i_cmd_addr  in  AW  word address.
- i_cmd_data  in  DW  write data.
- i_cmd_sel  in  DW/8  byte selects.
- i_abort  in  1  abandon the current transaction.
- o_cmd_busy  out  1  high while a transaction is outstanding.
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  bus control.
- o_wb_addr  out  AW  bus address.
- o_wb_data  out  DW  bus write data.
- o_wb_sel  out  DW/8  bus byte selects.
- i_wb_stall, i_wb_ack, i_wb_err  in  1 each  bus return signals.
- i_wb_data  in  DW  bus read data.
- o_rsp_stb  out  1  one-cycle completion pulse.
- o_rsp_err  out  1  completion was bus error, abort or timeout.
- o_rsp_timeout  out  1  completion was a timeout.
- o_rsp_data  out  DW  read data, valid with o_rsp_stb.

Behaviour:
- Reset (async): state IDLE. o_wb_cyc, o_wb_stb, o_cmd_busy, o_rsp_stb, o_rsp_err and o_rsp_timeout are 0. o_wb_addr, o_wb_data, o_wb_sel, o_wb_we and o_rsp_data are 0. Timeout counter is 0.
- Reset mid-transaction: cyc/stb drop immediately and no response is generated.
- States and transitions:
  - IDLE: o_cmd_busy=0. If i_cmd_stb, latch we/addr/data/sel onto the o_wb_* registers, assert o_wb_cyc=o_wb_stb=1 at the next edge, clear the counter, go to REQ.
  - REQ: cyc=stb=1 and held stable while i_wb_stall=1. On an edge with i_wb_stall=0, drop stb and go to WAIT.
  - WAIT: cyc=1, stb=0. Wait for i_wb_ack or i_wb_err.
  - Completion: from REQ or WAIT, on the edge where ack/err/abort/timeout is sampled, drop cyc and stb, pulse o_rsp_stb for exactly 1 cycle, return to IDLE.
- Ack in REQ: ack sampled in REQ with stall=0 (zero-wait slave) counts as completion.
- Latency: command edge N → cyc/stb high in cycle N+1. With no stall and ack in cycle N+2, o_rsp_stb is high in cycle N+3.
- Back-to-back commands: o_cmd_busy=0 in the response cycle, so a new command may be accepted there. The new cyc rises the cycle after, giving ≥1 cycle of cyc low between transactions.
- o_rsp_data: captured from i_wb_data on an ack completion of a read. On writes and error completions it holds its previous value.
- Error flags:
  - ack and err in the same cycle: err wins, so o_rsp_err=1.
  - i_abort in REQ/WAIT: completes with o_rsp_err=1, o_rsp_timeout=0. i_abort is ignored in IDLE.
  - Abort outranks ack/err sampled in the same cycle.
- Stray ack/err while IDLE are ignored.
- i_cmd_stb while busy is ignored and not queued. The caller must hold the command until it sees busy=0.
- Timeout counter: increments every cycle in REQ/WAIT and saturates. When it reaches TIMEOUT_CYCLES-1 with no ack/err, complete with o_rsp_err=1 and o_rsp_timeout=1. The count includes stalled cycles.

Optional Feature:
- Macro WBM_TIMEOUT_EN.
- Defined: timeout counter and o_rsp_timeout are active as described above.
- Undefined: no counter is built, o_rsp_timeout is tied 0, and a transaction waits indefinitely for ack/err/i_abort.

Test Plan:
- Write addr 0x2081, data 0xDEADBEEF, sel 0xF, no stall, ack one cycle after stb → cyc high 2 cycles, stb high 1 cycle with addr/data correct; o_rsp_stb one pulse with err=0, 3 cycles after command.
- Read addr 0x2080, stall held 3 cycles, ack with i_wb_data=0x20170622 → stb high 4 cycles with addr stable; o_rsp_data=0x20170622, err=0.
- Read to unmapped 0x0000, slave returns err → o_rsp_stb with o_rsp_err=1, o_rsp_timeout=0, o_rsp_data unchanged.
- WBM_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never acks → cyc drops after 16 cycles; rsp_stb with err=1, timeout=1. Without the macro, cyc stays high until i_abort, then err=1, timeout=0.
- Issue a command in the response cycle of the previous one → accepted, cyc low exactly 1 cycle between transactions. A command while busy is ignored and produces no second bus cycle.
- Assert i_reset during WAIT → cyc/stb/busy go 0 asynchronously, no o_rsp_stb. The first command after reset release completes normally.
